// File: rtl/float_to_integer.sv
// float_to_integer: IEEE-754 single -> int32 converter; significand aligned one bit per cycle.
// Latency: out_valid rises count+2 edges after accept (count = alignment shifts, 0..24).
// Backpressure: in_ready only in IDLE; result/Exception held in DONE until out_ready.
// Optional feature macro: ROUND_NEAREST_EN (round-to-nearest-even; otherwise truncate toward zero).
module float_to_integer #(
  parameter logic [31:0] EXCEPTION_RESULT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Exception
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic        sign;
  logic        exc;
  logic        left;
  logic [4:0]  count;
  logic [31:0] mag;
  logic        guard;
  logic        sticky;
  logic [31:0] res;

  // capture-time classification
  logic [7:0]  cap_exp;
  logic [22:0] cap_mant;
  logic [31:0] cap_mag;
  logic [4:0]  cap_cnt;
  logic        cap_left;
  logic        cap_exc;

  // ROUND-stage arithmetic
  logic        round_up;
  logic [31:0] rounded;
  logic [31:0] signed_val;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res;
  assign Exception = exc & (state == DONE);

  // Classify the operand; the exponent is compared directly instead of k=e-127
  // (k>=31 <=> e>=158, k>=23 <=> e>=150, k==-1 <=> e==126, k<=-2 <=> e<=125).
  always_comb begin
    cap_exp  = a_operand[30:23];
    cap_mant = a_operand[22:0];
    cap_mag  = {8'b0, 1'b1, cap_mant};
    cap_cnt  = 5'd0;
    cap_left = 1'b0;
    cap_exc  = 1'b0;
    if (cap_exp == 8'hFF) begin
      cap_exc = 1'b1;
    end else if (cap_exp <= 8'd125) begin
      // zero, denormal and |x| < 0.5 all produce 0
      cap_mag = 32'd0;
    end else if (cap_exp == 8'd126) begin
      // 0.5 <= |x| < 1: shift everything into guard/sticky; truncation yields 0,
      // and both builds keep the same latency
      cap_cnt = 5'd24;
    end else if (cap_exp >= 8'd158) begin
      if (a_operand[31] && cap_exp == 8'd158 && cap_mant == 23'd0) begin
        cap_left = 1'b1;
        cap_cnt  = 5'd8;
      end else begin
        cap_exc = 1'b1;
      end
    end else if (cap_exp >= 8'd150) begin
      // left shift by k-23 = e-150 (0..7); mod-32 arithmetic on the low bits is exact
      cap_left = 1'b1;
      cap_cnt  = cap_exp[4:0] - 5'd22;
    end else begin
      // right shift by 23-k = 150-e (1..23)
      cap_cnt = 5'd22 - cap_exp[4:0];
    end
  end

  // Rounding on the magnitude, then sign applied (sign-magnitude symmetric)
  always_comb begin
`ifdef ROUND_NEAREST_EN
    round_up = guard & (sticky | mag[0]);
`else
    round_up = 1'b0;
`endif
    rounded    = mag + {31'b0, round_up};
    signed_val = sign ? (~rounded + 32'd1) : rounded;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sign   <= 1'b0;
      exc    <= 1'b0;
      left   <= 1'b0;
      count  <= 5'd0;
      mag    <= 32'd0;
      guard  <= 1'b0;
      sticky <= 1'b0;
      res    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign   <= a_operand[31];
            exc    <= cap_exc;
            left   <= cap_left;
            count  <= cap_cnt;
            mag    <= cap_mag;
            guard  <= 1'b0;
            sticky <= 1'b0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (count != 5'd0) begin
            if (left) begin
              mag <= {mag[30:0], 1'b0};
            end else begin
              mag    <= {1'b0, mag[31:1]};
              guard  <= mag[0];
              sticky <= sticky | guard;
            end
            count <= count - 5'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          res   <= exc ? EXCEPTION_RESULT : signed_val;
          state <= DONE;
        end
        default: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_integer.sv
// Directed-vector bench for float_to_integer: values, Exception and latency,
// plus held-output and mid-conversion reset sequences.
module tb_float_to_integer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        Exception;

  int checks = 0;
  int passed = 0;

  float_to_integer #(.EXCEPTION_RESULT(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_operand (a_operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .Exception (Exception)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] r_rne;
    logic [31:0] r_trn;
    logic        exc;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h, want %h", name, act, exp);
    else
      passed++;
  endtask

  // Present an operand for one accept edge (DUT assumed in IDLE); returns #1 after that edge.
  task automatic start_op(input logic [31:0] a);
    @(negedge clk);
    in_valid  = 1'b1;
    a_operand = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after accept until out_valid; -1 if the bound expires.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) cyc = -1;
  endtask

  logic [31:0] exp_r;
  logic [31:0] held;
  int          lat;

  initial begin
    //           a             rne           trunc         exc  lat
    vecs[0]  = '{32'h42F6E979, 32'h0000007B, 32'h0000007B, 1'b0, 19};
    vecs[1]  = '{32'hC2280000, 32'hFFFFFFD6, 32'hFFFFFFD6, 1'b0, 20};
    vecs[2]  = '{32'hCF000000, 32'h80000000, 32'h80000000, 1'b0, 10};
    vecs[3]  = '{32'h4F000000, 32'h00000000, 32'h00000000, 1'b1, 2};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h00000000, 1'b1, 2};
    vecs[5]  = '{32'h7FC00000, 32'h00000000, 32'h00000000, 1'b1, 2};
    vecs[6]  = '{32'h40200000, 32'h00000002, 32'h00000002, 1'b0, 24};
    vecs[7]  = '{32'h40600000, 32'h00000004, 32'h00000003, 1'b0, 24};
    vecs[8]  = '{32'hC0600000, 32'hFFFFFFFC, 32'hFFFFFFFD, 1'b0, 24};
    vecs[9]  = '{32'h3F400000, 32'h00000001, 32'h00000000, 1'b0, 26};
    vecs[10] = '{32'h3F000000, 32'h00000000, 32'h00000000, 1'b0, 26};
    vecs[11] = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 2};
    vecs[12] = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 2};
    vecs[13] = '{32'h3E800000, 32'h00000000, 32'h00000000, 1'b0, 2};
    vecs[14] = '{32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80, 1'b0, 9};
    vecs[15] = '{32'hCF000001, 32'h00000000, 32'h00000000, 1'b1, 2};
    vecs[16] = '{32'h3F800000, 32'h00000001, 32'h00000001, 1'b0, 25};
    vecs[17] = '{32'hCB000001, 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2};

    reset     = 1'b1;
    in_valid  = 1'b0;
    a_operand = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result",    result,             32'd0);
    chk("reset_exception", {31'b0, Exception}, 32'd0);

    for (int i = 0; i < NV; i++) begin
`ifdef ROUND_NEAREST_EN
      exp_r = vecs[i].r_rne;
`else
      exp_r = vecs[i].r_trn;
`endif
      start_op(vecs[i].a);
      wait_valid(lat);
      chk($sformatf("latency[%h]", vecs[i].a), lat, vecs[i].lat);
      chk($sformatf("result[%h]", vecs[i].a), result, exp_r);
      chk($sformatf("exception[%h]", vecs[i].a), {31'b0, Exception}, {31'b0, vecs[i].exc});
      @(posedge clk);
      #1;
      chk($sformatf("release[%h]", vecs[i].a), {30'b0, out_valid, in_ready}, 32'd1);
    end

    // Hold the result in DONE with out_ready low
    out_ready = 1'b0;
    start_op(32'hC2280000);
    wait_valid(lat);
    chk("hold_latency", lat, 20);
    held = 32'hFFFFFFD6;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_result[%0d]", c), result, held);
      chk($sformatf("hold_flags[%0d]", c), {30'b0, out_valid, in_ready}, 32'd2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release", {30'b0, out_valid, in_ready}, 32'd1);

    // Reset in the middle of SHIFT discards the conversion
    start_op(32'h3F800000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result",    result,             32'd0);
    chk("midrst_exception", {31'b0, Exception}, 32'd0);
    start_op(32'h42F6E979);
    wait_valid(lat);
    chk("post_rst_latency", lat, 19);
    chk("post_rst_result",  result, 32'h0000007B);
    chk("post_rst_exc",     {31'b0, Exception}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
